// File: rtl/dmem_arbiter.sv
// Two-requester (core / loader) front end for the data memory: round-robin grant,
// legality check, and sequencing into single-cycle writes or registered reads.
module dmem_arbiter #(
    parameter int MEM_BYTES     = 21,
    parameter bit RR_RESET_CORE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [1:0]  core_sec_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic        core_err_o,
    output logic [31:0] core_rdata_o,
    input  logic        ldr_req_i,
    input  logic        ldr_we_i,
    input  logic [1:0]  ldr_sec_i,
    input  logic [31:0] ldr_addr_i,
    input  logic [31:0] ldr_wdata_i,
    output logic        ldr_gnt_o,
    output logic        ldr_rvalid_o,
    output logic        ldr_err_o,
    output logic [31:0] ldr_rdata_o,
    output logic        mem_rw_o,
    output logic [1:0]  mem_sec_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a requester holds req and its fields stable until it sees gnt (a
    // one-cycle pulse, IDLE only); exactly one rvalid pulse follows each gnt, with err
    // and rdata valid in that same cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_RDWAIT = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner_ldr;
    logic        r_err;
    logic        r_prio_core;
    logic [1:0]  r_sec;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_core_rdata;
    logic [31:0] r_ldr_rdata;

    logic        w_idle;
    logic        w_pick_core;
    logic        w_pick_ldr;
    logic        w_pick;
    logic        w_we;
    logic [1:0]  w_sec;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [32:0] w_nbytes;
    logic [32:0] w_last;
    logic        w_illegal;
    logic [31:0] w_load;

    assign w_idle      = (r_state == S_IDLE);
    // r_prio_core names the requester that wins the next tie (the one not granted last).
    assign w_pick_core = w_idle && core_req_i && (!ldr_req_i || r_prio_core);
    assign w_pick_ldr  = w_idle && ldr_req_i && (!core_req_i || !r_prio_core);
    assign w_pick      = w_pick_core || w_pick_ldr;

    assign w_we    = w_pick_ldr ? ldr_we_i    : core_we_i;
    assign w_sec   = w_pick_ldr ? ldr_sec_i   : core_sec_i;
    assign w_addr  = w_pick_ldr ? ldr_addr_i  : core_addr_i;
    assign w_wdata = w_pick_ldr ? ldr_wdata_i : core_wdata_i;

    // Range check in 33 bits so an address near 2^32 cannot wrap into range.
    always_comb begin
        w_nbytes  = 33'd1;
        w_illegal = 1'b0;
        case (w_sec)
            2'b01:   w_nbytes = 33'd2;
            2'b10:   w_nbytes = 33'd4;
            default: w_nbytes = 33'd1;
        endcase
        w_last = {1'b0, w_addr} + w_nbytes - 33'd1;
        if (w_sec == 2'b11) begin
            w_illegal = 1'b1;
        end else if ((w_sec == 2'b01) && w_addr[0]) begin
            w_illegal = 1'b1;
        end else if ((w_sec == 2'b10) && (w_addr[1:0] != 2'b00)) begin
            w_illegal = 1'b1;
        end else if (w_last > 33'(MEM_BYTES - 1)) begin
            w_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick) begin
                    if (w_illegal) begin
                        w_next = S_RESP;
                    end else if (w_we) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ:   w_next = S_RDWAIT;
            S_RDWAIT: w_next = S_RESP;
            S_WRITE:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The memory writes whenever mem_rw_o is low, so only WRITE may lower it; the
    // registered request reaches the memory pins only in the states that use it.
    always_comb begin
        mem_rw_o    = 1'b1;
        mem_sec_o   = 2'b10;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        case (r_state)
            S_WRITE: begin
                mem_rw_o    = 1'b0;
                mem_sec_o   = r_sec;
                mem_addr_o  = r_addr;
                mem_wdata_o = r_wdata;
            end
            S_READ, S_RDWAIT: begin
                mem_sec_o  = r_sec;
                mem_addr_o = r_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_sec)
            2'b00:   w_load = {24'h0, mem_rdata_i[31:24]};
            2'b01:   w_load = {16'h0, mem_rdata_i[31:16]};
            default: w_load = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_ldr  <= 1'b0;
            r_err        <= 1'b0;
            r_prio_core  <= RR_RESET_CORE;
            r_sec        <= 2'b10;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_core_rdata <= 32'h0;
            r_ldr_rdata  <= 32'h0;
        end else begin
            if (w_pick) begin
                r_owner_ldr <= w_pick_ldr;
                r_err       <= w_illegal;
                r_prio_core <= w_pick_ldr;
                r_sec       <= w_sec;
                r_addr      <= w_addr;
                r_wdata     <= w_wdata;
            end
            // Load data lands in the owner's rdata register as RESP begins.
            if (r_state == S_RDWAIT) begin
                if (r_owner_ldr) begin
                    r_ldr_rdata <= w_load;
                end else begin
                    r_core_rdata <= w_load;
                end
            end
        end
    end

    assign core_gnt_o    = w_pick_core;
    assign ldr_gnt_o     = w_pick_ldr;
    assign core_rvalid_o = (r_state == S_RESP) && !r_owner_ldr;
    assign ldr_rvalid_o  = (r_state == S_RESP) && r_owner_ldr;
    assign core_err_o    = core_rvalid_o && r_err;
    assign ldr_err_o     = ldr_rvalid_o && r_err;
    assign core_rdata_o  = r_core_rdata;
    assign ldr_rdata_o   = r_ldr_rdata;
    assign busy_o        = !w_idle;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory emulator on the memory port
// and a transaction-level reference model for responses, latency and arbitration.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_i, core_we_i;
  logic [1:0]  core_sec_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic        ldr_req_i, ldr_we_i;
  logic [1:0]  ldr_sec_i;
  logic [31:0] ldr_addr_i, ldr_wdata_i;
  logic        ldr_gnt_o, ldr_rvalid_o, ldr_err_o;
  logic [31:0] ldr_rdata_o;
  logic        mem_rw_o;
  logic [1:0]  mem_sec_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        busy_o;
  logic [2:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .RR_RESET_CORE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_sec_i(core_sec_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_err_o(core_err_o),
    .core_rdata_o(core_rdata_o),
    .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_sec_i(ldr_sec_i),
    .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
    .ldr_gnt_o(ldr_gnt_o), .ldr_rvalid_o(ldr_rvalid_o), .ldr_err_o(ldr_err_o),
    .ldr_rdata_o(ldr_rdata_o),
    .mem_rw_o(mem_rw_o), .mem_sec_o(mem_sec_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- memory emulator (big-endian, registered read) ----------------
  logic [7:0] emu_mem [0:MEM_BYTES-1];
  always @(posedge clk) begin
    int nb;
    logic [31:0] w;
    if (mem_rw_o === 1'b0) begin
      nb = (mem_sec_o == 2'b00) ? 1 : ((mem_sec_o == 2'b01) ? 2 : 4);
      for (int i = 0; i < nb; i++)
        if ({32'h0, mem_addr_o} + 64'(i) < 64'(MEM_BYTES))
          emu_mem[mem_addr_o + i] <= 8'(mem_wdata_o >> (8 * (nb - 1 - i)));
    end
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w = (w << 8) | (({32'h0, mem_addr_o} + 64'(i) < 64'(MEM_BYTES)) ? 32'(emu_mem[mem_addr_o + i]) : 32'h0);
    mem_rdata_i <= w;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic [31:0] ref_rdata [2];
  bit          ref_tie_ldr;

  function automatic int ref_nbytes(input logic [1:0] sec);
    return (sec == 2'b00) ? 1 : ((sec == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit ref_illegal(input logic [1:0] sec, input logic [31:0] addr);
    longint a;
    int nb;
    a  = longint'({32'h0, addr});
    nb = ref_nbytes(sec);
    if (sec == 2'b11) return 1'b1;
    if (a % nb != 0) return 1'b1;
    if (a + nb > MEM_BYTES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void ref_apply(input bit who, input bit we, input logic [1:0] sec,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output int lat, output bit err, output logic [31:0] rdata);
    int nb;
    logic [31:0] v;
    nb  = ref_nbytes(sec);
    err = ref_illegal(sec, addr);
    ref_tie_ldr = !who;
    if (err) begin
      lat = 1;
    end else if (we) begin
      lat = 2;
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wdata >> (8 * (nb - 1 - i)));
    end else begin
      lat = 3;
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[addr + i]);
      ref_rdata[who] = v;
    end
    rdata = ref_rdata[who];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit who, input bit req, input bit we, input logic [1:0] sec,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (!who) begin
      core_req_i = req; core_we_i = we; core_sec_i = sec; core_addr_i = addr; core_wdata_i = wdata;
    end else begin
      ldr_req_i = req; ldr_we_i = we; ldr_sec_i = sec; ldr_addr_i = addr; ldr_wdata_i = wdata;
    end
  endtask

  // Runs one transaction from an idle DUT and reports what was observed; latencies are
  // counted in cycles after the grant cycle.
  task automatic run_txn(input bit who, input bit we, input logic [1:0] sec,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int gwait, output int lat, output bit err,
                         output logic [31:0] rdata, output int wr_cyc, output int wr_at,
                         output bit addr_seen, output bit other_act);
    gwait = 0; lat = 0; err = 1'b0; rdata = 32'h0; wr_cyc = 0; wr_at = 0;
    addr_seen = 1'b0; other_act = 1'b0;
    @(posedge clk); #1;
    set_req(who, 1'b1, we, sec, addr, wdata);
    @(negedge clk);
    while (((who ? ldr_gnt_o : core_gnt_o) !== 1'b1) && gwait < 20) begin
      gwait++;
      @(negedge clk);
    end
    if ((who ? core_gnt_o : ldr_gnt_o) === 1'b1) other_act = 1'b1;
    @(posedge clk); #1;
    set_req(who, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_rw_o === 1'b0) begin
        wr_cyc++;
        if (wr_at == 0) wr_at = k;
      end
      if (mem_addr_o === addr) addr_seen = 1'b1;
      if ((who ? core_rvalid_o : ldr_rvalid_o) === 1'b1 || core_gnt_o === 1'b1 || ldr_gnt_o === 1'b1)
        other_act = 1'b1;
      if ((who ? ldr_rvalid_o : core_rvalid_o) === 1'b1 && lat == 0) begin
        lat   = k;
        err   = who ? ldr_err_o : core_err_o;
        rdata = who ? ldr_rdata_o : core_rdata_o;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    checks++;
    if ({core_gnt_o, ldr_gnt_o, core_rvalid_o, ldr_rvalid_o, core_err_o, ldr_err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 000000",
        {core_gnt_o, ldr_gnt_o, core_rvalid_o, ldr_rvalid_o, core_err_o, ldr_err_o});
    end
    checks++;
    if (core_rdata_o !== 32'h0 || ldr_rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", core_rdata_o, ldr_rdata_o);
    end
    checks++;
    if (mem_rw_o !== 1'b1 || mem_sec_o !== 2'b10) begin
      errors++; $display("FAIL reset_mem_ctrl: got rw=%b sec=%b want rw=1 sec=10", mem_rw_o, mem_sec_o);
    end
    checks++;
    if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_mem_data: got addr=%h wdata=%h busy=%b want 0/0/0",
        mem_addr_o, mem_wdata_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_tie_ldr = 1'b0;
    ref_rdata[0] = 32'h0;
    ref_rdata[1] = 32'h0;
  endtask

  task automatic test_store_load();
    int gw, lat, wc, wa, el; bit er, as, oa, ee; logic [31:0] rd, ed;
    ref_apply(1'b0, 1'b1, 2'b10, 32'd4, 32'hDEADBEEF, el, ee, ed);
    run_txn(1'b0, 1'b1, 2'b10, 32'd4, 32'hDEADBEEF, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (gw !== 0) begin errors++; $display("FAIL store_grant: got wait=%0d want 0", gw); end
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++; $display("FAIL store_resp: got lat=%0d err=%b want lat=2 err=0", lat, er);
    end
    checks++;
    if (wc !== 1 || wa !== 1) begin
      errors++; $display("FAIL store_write_pulse: got cycles=%0d at=%0d want 1 at 1", wc, wa);
    end
    ref_apply(1'b0, 1'b0, 2'b10, 32'd4, 32'h0, el, ee, ed);
    run_txn(1'b0, 1'b0, 2'b10, 32'd4, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load: got lat=%0d err=%b data=%h want 3/0/deadbeef", lat, er, rd);
    end
    checks++;
    if (wc !== 0 || oa !== 1'b0) begin
      errors++; $display("FAIL load_side_effects: got writes=%0d other=%b want 0/0", wc, oa);
    end
  endtask

  task automatic test_byte_half();
    int gw, lat, wc, wa, el; bit er, as, oa, ee; logic [31:0] rd, ed;
    ref_apply(1'b1, 1'b0, 2'b00, 32'd5, 32'h0, el, ee, ed);
    run_txn(1'b1, 1'b0, 2'b00, 32'd5, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 3 || rd !== 32'h000000AD || oa !== 1'b0) begin
      errors++; $display("FAIL byte_load: got lat=%0d data=%h other=%b want 3/000000ad/0", lat, rd, oa);
    end
    ref_apply(1'b0, 1'b0, 2'b01, 32'd6, 32'h0, el, ee, ed);
    run_txn(1'b0, 1'b0, 2'b01, 32'd6, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 3 || rd !== 32'h0000BEEF) begin
      errors++; $display("FAIL half_load: got lat=%0d data=%h want 3/0000beef", lat, rd);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  sec_t [5];
    logic [31:0] addr_t [5];
    int gw, lat, wc, wa, el; bit er, as, oa, ee; logic [31:0] rd, ed;
    sec_t  = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    addr_t = '{32'd2, 32'd1, 32'd8, 32'd20, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      ref_apply(i[0], i[1], sec_t[i], addr_t[i], 32'h12345678, el, ee, ed);
      run_txn(i[0], i[1], sec_t[i], addr_t[i], 32'h12345678, gw, lat, er, rd, wc, wa, as, oa);
      checks++;
      if (gw !== 0 || lat !== 1 || er !== 1'b1) begin
        errors++; $display("FAIL error_resp[%0d]: got wait=%0d lat=%0d err=%b want 0/1/1", i, gw, lat, er);
      end
      checks++;
      if (wc !== 0 || as !== 1'b0 || rd !== ed) begin
        errors++; $display("FAIL error_no_access[%0d]: got writes=%0d addr_seen=%b data=%h want 0/0/%h",
          i, wc, as, rd, ed);
      end
    end
  endtask

  task automatic test_boundary();
    int gw, lat, wc, wa, el; bit er, as, oa, ee; logic [31:0] rd, ed;
    ref_apply(1'b0, 1'b0, 2'b00, 32'd20, 32'h0, el, ee, ed);
    run_txn(1'b0, 1'b0, 2'b00, 32'd20, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== ed) begin
      errors++; $display("FAIL last_byte_load: got lat=%0d err=%b data=%h want 3/0/%h", lat, er, rd, ed);
    end
    ref_apply(1'b0, 1'b1, 2'b00, 32'd20, 32'h0000005A, el, ee, ed);
    run_txn(1'b0, 1'b1, 2'b00, 32'd20, 32'h0000005A, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 2 || er !== 1'b0 || wc !== 1) begin
      errors++; $display("FAIL last_byte_store: got lat=%0d err=%b writes=%0d want 2/0/1", lat, er, wc);
    end
    ref_apply(1'b1, 1'b0, 2'b00, 32'd20, 32'h0, el, ee, ed);
    run_txn(1'b1, 1'b0, 2'b00, 32'd20, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (rd !== 32'h0000005A || er !== 1'b0) begin
      errors++; $display("FAIL last_byte_readback: got data=%h err=%b want 0000005a/0", rd, er);
    end
    ref_apply(1'b1, 1'b0, 2'b01, 32'd20, 32'h0, el, ee, ed);
    run_txn(1'b1, 1'b0, 2'b01, 32'd20, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL half_past_end: got lat=%0d err=%b want 1/1", lat, er);
    end
    ref_apply(1'b0, 1'b0, 2'b10, 32'd16, 32'h0, el, ee, ed);
    run_txn(1'b0, 1'b0, 2'b10, 32'd16, 32'h0, gw, lat, er, rd, wc, wa, as, oa);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== ed) begin
      errors++; $display("FAIL last_word_load: got lat=%0d err=%b data=%h want 3/0/%h", lat, er, rd, ed);
    end
  endtask

  task automatic test_arbitration();
    int ng, both, cyc, el; bit got, exp_who, ee; logic [31:0] ed;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 32'd0, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'b10, 32'd4, 32'h0);
    exp_who = ref_tie_ldr;
    ng = 0; both = 0; cyc = 0;
    while (ng < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (core_gnt_o === 1'b1 && ldr_gnt_o === 1'b1) begin
        both++;
      end else if (core_gnt_o === 1'b1 || ldr_gnt_o === 1'b1) begin
        got = (ldr_gnt_o === 1'b1);
        checks++;
        if (got !== exp_who) begin
          errors++; $display("FAIL rr_order[%0d]: got %s want %s", ng, got ? "ldr" : "core", exp_who ? "ldr" : "core");
        end
        ref_apply(got, 1'b0, 2'b10, got ? 32'd4 : 32'd0, 32'h0, el, ee, ed);
        exp_who = !got;
        ng++;
      end
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (6) @(negedge clk);
    checks++;
    if (ng !== 6 || both !== 0) begin
      errors++; $display("FAIL rr_grants: got grants=%0d double=%0d want 6/0", ng, both);
    end
    checks++;
    if (core_rdata_o !== ref_rdata[0] || ldr_rdata_o !== ref_rdata[1]) begin
      errors++; $display("FAIL rr_rdata: got %h/%h want %h/%h", core_rdata_o, ldr_rdata_o, ref_rdata[0], ref_rdata[1]);
    end
  endtask

  task automatic test_random();
    int gw, lat, wc, wa, el, nb; bit er, as, oa, ee, who, we; logic [1:0] sec;
    logic [31:0] addr, wdata, rd, ed, exp_rd;
    for (int n = 0; n < 40; n++) begin
      who   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      sec   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      nb    = ref_nbytes(sec);
      wdata = $urandom;
      case ($urandom_range(0, 4))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(0, MEM_BYTES + 3));
        default: addr = 32'(($urandom_range(0, MEM_BYTES - 1) / nb) * nb);
      endcase
      ref_apply(who, we, sec, addr, wdata, el, ee, ed);
      exp_q.push_back(ed);
      run_txn(who, we, sec, addr, wdata, gw, lat, er, rd, wc, wa, as, oa);
      exp_rd = exp_q.pop_front();
      checks++;
      if (gw !== 0 || lat !== el || er !== ee) begin
        errors++; $display("FAIL rand_resp[%0d]: got wait=%0d lat=%0d err=%b want 0/%0d/%b (sec=%b addr=%h)",
          n, gw, lat, er, el, ee, sec, addr);
      end
      checks++;
      if (rd !== exp_rd) begin
        errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, exp_rd);
      end
      checks++;
      if (wc !== ((!ee && we) ? 1 : 0) || oa !== 1'b0 || (ee && addr != 32'h0 && as)) begin
        errors++; $display("FAIL rand_mem_port[%0d]: got writes=%0d other=%b addr_seen=%b want %0d/0/%b",
          n, wc, oa, as, (!ee && we) ? 1 : 0, !ee);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int el; bit ee, rv; logic [31:0] ed;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 2'b00, 32'd3, 32'h00000077);
    @(negedge clk);
    checks++;
    if (core_gnt_o !== 1'b1) begin errors++; $display("FAIL rstw_grant: got %b want 1", core_gnt_o); end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    checks++;
    if (mem_rw_o !== 1'b0) begin errors++; $display("FAIL rstw_in_write: got rw=%b want 0", mem_rw_o); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_rw_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rstw_abort: got rw=%b busy=%b want 1/0", mem_rw_o, busy_o);
    end
    rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rv = rv | core_rvalid_o | ldr_rvalid_o;
    end
    rst = 1'b0;
    ref_tie_ldr = 1'b0;
    ref_rdata[0] = 32'h0;
    ref_rdata[1] = 32'h0;
    repeat (3) begin
      @(negedge clk);
      rv = rv | core_rvalid_o | ldr_rvalid_o;
    end
    checks++;
    if (rv !== 1'b0 || core_rdata_o !== 32'h0) begin
      errors++; $display("FAIL rstw_no_resp: got rvalid_seen=%b rdata=%h want 0/0", rv, core_rdata_o);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b0, 2'b00, 32'd3, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 2'b00, 32'd4, 32'h0);
    @(negedge clk);
    checks++;
    if (core_gnt_o !== 1'b1 || ldr_gnt_o !== 1'b0) begin
      errors++; $display("FAIL rstw_first_tie: got core=%b ldr=%b want 1/0", core_gnt_o, ldr_gnt_o);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    ref_apply(1'b0, 1'b0, 2'b00, 32'd3, 32'h0, el, ee, ed);
    repeat (6) @(negedge clk);
    checks++;
    if (core_rdata_o !== ed) begin
      errors++; $display("FAIL rstw_mem_intact: got %h want %h", core_rdata_o, ed);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      emu_mem[i] = 8'h0;
      ref_mem[i] = 8'h0;
    end
    test_reset();
    test_store_load();
    test_byte_half();
    test_errors();
    test_boundary();
    test_arbitration();
    test_random();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Controller in front of the byte-addressed data memory stage. Arbitrates between two requesters, the core load/store port ("core") and the program/debug loader ("ldr").
- Sequences each granted access into the memory's single-cycle write or registered read.
- Checks size, alignment and range before any access; returns one response per grant.
- Sits between the execute stage / loader and the memory stage. It is the only driver of the memory's control, address and write-data inputs.

Parameters:
MEM_BYTES, 21, number of memory bytes; valid byte addresses are 0..MEM_BYTES-1.
RR_RESET_CORE, 1, after reset the first tie goes to core (1) or ldr (0).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
core_req_i  in  1  core request; held stable with its fields until core_gnt_o
core_we_i  in  1  1 = store, 0 = load
core_sec_i  in  2  size: 00 byte, 01 half, 10 word, 11 illegal
core_addr_i  in  32  byte address
core_wdata_i  in  32  store data, right-aligned
core_gnt_o  out  1  one-cycle grant pulse
core_rvalid_o  out  1  one-cycle response pulse, for loads and stores
core_err_o  out  1  error flag, valid with core_rvalid_o
core_rdata_o  out  32  load data, right-aligned, zero-extended
ldr_req_i, ldr_we_i, ldr_sec_i, ldr_addr_i, ldr_wdata_i, ldr_gnt_o, ldr_rvalid_o, ldr_err_o, ldr_rdata_o: same widths and meaning for the loader
mem_rw_o  out  1  to memory: 1 read, 0 write
mem_sec_o  out  2  to memory: access size
mem_addr_o  out  32  to memory: byte address
mem_wdata_o  out  32  to memory: write data
mem_rdata_i  in  32  from memory: registered read word; addressed byte in [31:24]
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous:
  - state=IDLE; RR pointer initialised per RR_RESET_CORE.
  - All gnt, rvalid and err outputs 0; rdata outputs 0.
  - mem_rw_o=1, mem_sec_o=10, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-transaction aborts it with no response. mem_rw_o is 1 immediately, so no spurious write.
- Default drive: mem_rw_o=1 in every state except WRITE. The memory writes combinationally when mem_rw_o=0, so this prevents unintended writes.
- FSM states: IDLE, READ, RDWAIT, WRITE, RESP.
- IDLE:
  - If exactly one requester has req=1, it is selected. If both do, the one not granted last is selected.
  - The selected gnt pulses combinationally in this cycle, and the request is registered at the clock edge.
  - The RR pointer is updated to the selected requester.
  - Next state: RESP with err=1 if the request is illegal; else WRITE if we=1; else READ.
- Illegal request, checked in 33-bit arithmetic so there is no wrap-around:
  - sec=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr + nbytes - 1 > MEM_BYTES-1, where nbytes is 1, 2 or 4.
  - An illegal request never drives the memory.
- WRITE, exactly 1 cycle: drive mem_rw_o=0 with the registered sec, addr and wdata (passed unchanged) -> RESP.
- READ, 1 cycle: drive mem_rw_o=1 with the registered addr and sec -> RDWAIT. The memory registers its data at the end of this cycle.
- RDWAIT, 1 cycle: addr is still driven.
  - mem_rdata_i is captured at the end of the cycle: byte {24'b0, [31:24]}, half {16'b0, [31:16]}, word [31:0].
  - -> RESP.
- RESP, 1 cycle:
  - Owner's rvalid=1 and err per check; owner's rdata_o is updated for loads only.
  - Writes and errors leave rdata_o unchanged; err=0 for legal requests.
  - -> IDLE.
- Latency from grant cycle T: load response at T+3, store at T+2, error at T+1. Next grant is no earlier than the IDLE cycle after RESP.
- Requests are ignored outside IDLE; gnt is never asserted outside IDLE. A requester may drop req before grant without effect.
- Outputs of the non-owner stay 0 throughout a transaction.

Test Plan:
- Word store then load:
  - core store sec=10, addr=4, wdata=0xDEADBEEF -> mem_rw_o=0 for exactly 1 cycle at T+1; rvalid at T+2 with err=0.
  - Subsequent load of addr=4 -> core_rdata_o=0xDEADBEEF at T+3.
- Byte and half loads after the word store: byte load addr=5 -> 0x000000AD; half load addr=6 -> 0x0000BEEF.
- Arbitration: core and ldr both request continuously with legal loads -> grants alternate core, ldr, core, ldr; no cycle has both gnt=1.
- Errors, each returns err=1 at T+1, mem_rw_o stays 1 and mem_addr_o is never driven with the request:
  - word addr=2;
  - half addr=1;
  - sec=11;
  - word addr=20 with MEM_BYTES=21;
  - word addr=0xFFFFFFFF.
- Boundary: byte load addr=20 with MEM_BYTES=21 -> err=0; store of byte 0x5A then load returns 0x0000005A.
- Reset during WRITE: assert rst mid-cycle -> mem_rw_o=1 immediately, no rvalid; after release, the first tie is granted to core.
